app_div: RTL

Sequential approximate unsigned divider, the inverse companion of the team's approximate multiplier (`app_mult`). It uses the same leading-one normalisation scheme as that block:
- normalise both operands by shifting left until the MSB is set,
- keep the top K bits of each,
- run a K-step restoring division on the truncated mantissas,
- shift the quotient back by the exponent difference.

A start/Done handshake lets the block sit beside the multiplier in the arithmetic subsystem.

---
 rtl/app_div_pkg.sv | 23 ++
 rtl/app_div_if.sv | 15 +
 rtl/app_div_restoring.sv | 62 ++++++
 rtl/app_div.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/app_div_pkg.sv
// Shared types and default sizing for the approximate divider.
package app_div_pkg;

  localparam int unsigned N_DEF = 16;
  localparam int unsigned K_DEF = 8;

  // Normalisation shift counters; the signed exponent adds one sign bit.
  localparam int unsigned CW = $clog2(N_DEF) + 1;
  localparam int unsigned SW = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DIV,
    S_DENORM,
    S_DONE
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/app_div_if.sv
// Start/Done handshake and operand/result bus of the approximate divider.
interface app_div_if #(
  parameter int unsigned N = 16
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] Q;
  logic         Done;
  logic         busy;
  logic         dz;

  modport master (output start, A, B, input Q, Done, busy, dz);
  modport slave  (input start, A, B, output Q, Done, busy, dz);
endinterface

// File: rtl/app_div_restoring.sv
// Restoring division on K-bit mantissas: one quotient bit per step, ITER steps.
module app_div_restoring #(
  parameter int unsigned K    = 8,
  parameter int unsigned ITER = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [K-1:0]    am_i,
  input  logic [K-1:0]    bm_i,
  output logic [ITER-1:0] q_o,
  output logic            done_o
);
  localparam int unsigned IW = $clog2(ITER + 1);

  logic [K:0]      rem_q, rem_d;
  logic [ITER-1:0] q_q, q_d;
  logic [IW-1:0]   it_q, it_d;
  logic            ge;
  logic [K-1:0]    diff;

  // rem stays below 2*bm, so the difference always fits in K bits.
  always_comb begin
    ge    = rem_q >= {1'b0, bm_i};
    diff  = ge ? K'(rem_q - {1'b0, bm_i}) : rem_q[K-1:0];
    rem_d = rem_q;
    q_d   = q_q;
    it_d  = it_q;
    if (clr_i) begin
      rem_d = '0;
      q_d   = '0;
      it_d  = '0;
    end else if (load_i) begin
      rem_d = {1'b0, am_i};
      q_d   = '0;
      it_d  = '0;
    end else if (step_i) begin
      rem_d = {diff, 1'b0};
      q_d   = (q_q << 1) | ITER'(ge);
      it_d  = it_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      q_q   <= '0;
      it_q  <= '0;
    end else begin
      rem_q <= rem_d;
      q_q   <= q_d;
      it_q  <= it_d;
    end
  end

  // q_o includes the bit resolved this cycle so the caller can take it on the last step.
  assign q_o    = q_d;
  assign done_o = step_i && (it_q == IW'(ITER - 1));

endmodule

// File: rtl/app_div.sv
// Sequential approximate unsigned divider using leading-one normalisation.
// Define APP_DIV_ROUND_EN for a K+1-step divide with half-up rounding.
module app_div
  import app_div_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned K = K_DEF
) (
  input logic      clk,
  input logic      rst,
  app_div_if.slave bus
);
  localparam int unsigned CWL = cnt_width(N);
  localparam int unsigned SWL = CWL + 1;
`ifdef APP_DIV_ROUND_EN
  localparam int unsigned ITER = K + 1;
  localparam int unsigned QFW  = K + 1;
`else
  localparam int unsigned ITER = K;
  localparam int unsigned QFW  = K;
`endif
  localparam logic signed [SWL-1:0] S_ZERO = '0;
  localparam logic signed [SWL-1:0] S_ONE  = {{(SWL-1){1'b0}}, 1'b1};
  localparam logic signed [SWL-1:0] S_MONE = '1;

  state_t                 state_q, state_d;
  logic [N-1:0]           ra_q, ra_d, rb_q, rb_d, w_q, w_d, qo_q, qo_d;
  logic [CWL-1:0]         cnta_q, cnta_d, cntb_q, cntb_d;
  logic signed [SWL-1:0]  s_q, s_d, s_calc;
  logic                   dz_q, dz_d;
  logic                   clr, load, step, div_done;
  logic                   msb_both, den_sat, den_last;
  logic [ITER-1:0]        q_div;
  logic [QFW-1:0]         q_fin;

  app_div_restoring #(.K(K), .ITER(ITER)) u_rest (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .load_i (load),
    .step_i (step),
    .am_i   (ra_q[N-1 -: K]),
    .bm_i   (rb_q[N-1 -: K]),
    .q_o    (q_div),
    .done_o (div_done)
  );

`ifdef APP_DIV_ROUND_EN
  logic [K+1:0] q_sum;
  assign q_sum = {1'b0, q_div} + 1'b1;
  assign q_fin = q_sum[K+1:1];
`else
  assign q_fin = q_div;
`endif

  assign msb_both = ra_q[N-1] && rb_q[N-1];
  assign s_calc   = $signed(SWL'(cntb_q) - SWL'(cnta_q) - SWL'(K - 1));
  assign den_sat  = (s_q > S_ZERO) && w_q[N-1];
  assign den_last = den_sat || (s_q == S_ONE) || (s_q == S_MONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (bus.A == '0 || bus.B == '0) ? S_DONE : S_NORM;
      S_NORM:   if (msb_both) state_d = S_DIV;
      S_DIV:    if (div_done) state_d = (s_calc == S_ZERO) ? S_DONE : S_DENORM;
      S_DENORM: if (den_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Done = (state_q == S_DONE);
    bus.busy = (state_q != S_IDLE);
    clr      = (state_q == S_IDLE) && bus.start;
    load     = (state_q == S_NORM) && msb_both;
    step     = (state_q == S_DIV);
  end

  always_comb begin
    ra_d   = ra_q;
    rb_d   = rb_q;
    cnta_d = cnta_q;
    cntb_d = cntb_q;
    s_d    = s_q;
    w_d    = w_q;
    qo_d   = qo_q;
    dz_d   = dz_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        ra_d   = bus.A;
        rb_d   = bus.B;
        cnta_d = '0;
        cntb_d = '0;
        if (bus.A == '0) begin
          qo_d = '0;
          dz_d = 1'b0;
        end else if (bus.B == '0) begin
          qo_d = '1;
          dz_d = 1'b1;
        end
      end
      S_NORM: begin
        if (!ra_q[N-1]) begin
          ra_d   = ra_q << 1;
          cnta_d = cnta_q + 1'b1;
        end
        if (!rb_q[N-1]) begin
          rb_d   = rb_q << 1;
          cntb_d = cntb_q + 1'b1;
        end
      end
      S_DIV: if (div_done) begin
        w_d = N'(q_fin);
        s_d = s_calc;
        if (s_calc == S_ZERO) begin
          qo_d = N'(q_fin);
          dz_d = 1'b0;
        end
      end
      S_DENORM: begin
        if (den_sat) begin
          w_d = '1;
        end else if (s_q > S_ZERO) begin
          w_d = w_q << 1;
          s_d = s_q - S_ONE;
        end else begin
          w_d = w_q >> 1;
          s_d = s_q + S_ONE;
        end
        if (den_last) begin
          qo_d = w_d;
          dz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Q/dz only change when a result completes, so they hold across the next operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      cnta_q <= '0;
      cntb_q <= '0;
      s_q    <= '0;
      w_q    <= '0;
      qo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      cnta_q <= cnta_d;
      cntb_q <= cntb_d;
      s_q    <= s_d;
      w_q    <= w_d;
      qo_q   <= qo_d;
      dz_q   <= dz_d;
    end
  end

  assign bus.Q  = qo_q;
  assign bus.dz = dz_q;

endmodule
